muldiv_sequencer: RTL

- Multi-cycle sequencer for the RV32M multiply/divide operations (funct7 = 0000001, R-type) that sits beside the single-cycle ALU in EX.
- Accepts one operation, iterates a radix-2 shift-add multiplier or restoring divider over XLEN cycles, and holds the pipeline stalled until the result is ready.
- Returns a one-cycle done pulse with the result, muxed into the EX result path in place of the ALU output.

---
 rtl/muldiv_sequencer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV32M multiply/divide unit beside the EX ALU.
// It accepts one M-extension operation, runs a radix-2 shift-add multiplier
// or a restoring divider for XLEN cycles while stalling the pipeline, then
// pulses done for one cycle with the sign-corrected result.
//
// Ports:
//   clk     rising-edge clock
//   reset   synchronous, active-high reset
//   start   EX holds an M-extension instruction
//   Funct3  operation select (MUL..REMU)
//   SrcA    rs1 operand after forwarding
//   SrcB    rs2 operand after forwarding
//   flush   EX flush; aborts the operation in flight, blocks acceptance
//   stall   freeze PC, IF/ID and ID/EX this cycle
//   done    Result valid this cycle
//   Result  operation result (holds its last value outside done)
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] Result
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_next;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;        // mul: product hi:lo, div: remainder:quotient
  logic [XLEN-1:0]   a_q;        // multiplicand / dividend bits still to shift in
  logic [XLEN-1:0]   b_q;        // multiplier bits still to consume / divisor
  logic [XLEN-1:0]   result_q;
  logic [2:0]        f_q;
  logic              neg_q;      // final two's-complement correction needed

  // Accept-cycle decode.
  logic            accept;
  logic            signed_a, signed_b, sign_a, sign_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf;

  // Per-iteration datapath.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_acc_next;
  logic [XLEN:0]     div_shift, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] div_acc_next;

  // Sign-corrected result candidates.
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   quo_fix, rem_fix, result_val;

  assign accept = (state == IDLE) && start && !flush;

  always_comb begin
    // NOTE: every signal driven here gets a value on every path first, so no latch is inferred.
    signed_a = 1'b0;
    signed_b = 1'b0;
    if (Funct3[2]) begin
      signed_a = !Funct3[0];              // DIV, REM
      signed_b = !Funct3[0];
    end else begin
      signed_a = (Funct3[1:0] != 2'b11);  // MUL, MULH, MULHSU
      signed_b = !Funct3[1];              // MUL, MULH
    end
    sign_a   = signed_a && SrcA[XLEN-1];
    sign_b   = signed_b && SrcB[XLEN-1];
    mag_a    = sign_a ? -SrcA : SrcA;
    mag_b    = sign_b ? -SrcB : SrcB;
    div_zero = Funct3[2] && (SrcB == '0);
    div_ovf  = Funct3[2] && !Funct3[0] && (SrcA == {1'b1, {(XLEN-1){1'b0}}}) && (&SrcB);
  end

  always_comb begin
    // Shift-add: add multiplicand into the upper half, then shift the whole
    // accumulator right; the carry re-enters at the top.
    mul_sum      = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (b_q[0] ? a_q : '0)};
    mul_acc_next = {mul_sum, acc[XLEN-1:1]};
    // Restoring divide: the next dividend bit shifts into the remainder; a
    // missing borrow means remainder >= divisor.
    div_shift    = {acc[2*XLEN-1:XLEN], a_q[XLEN-1]};
    div_diff     = div_shift - {1'b0, b_q};
    div_ge       = !div_diff[XLEN];
    div_acc_next = div_ge ? {div_diff[XLEN-1:0],  acc[XLEN-2:0], 1'b1}
                          : {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
  end

  always_comb begin
    product    = neg_q ? -acc : acc;
    quo_fix    = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix    = neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    result_val = '0;
    case (f_q)
      3'b000:                 result_val = product[XLEN-1:0];
      3'b001, 3'b010, 3'b011: result_val = product[2*XLEN-1:XLEN];
      3'b100, 3'b101:         result_val = quo_fix;
      default:                result_val = rem_fix;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = (div_zero || div_ovf) ? DONE : BUSY;
      BUSY: begin
        if (flush)                        state_next = IDLE;
        else if (cnt == CW'(XLEN - 1))    state_next = DONE;
      end
      DONE:    state_next = IDLE;  // start is still high here; never restart
      default: state_next = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    stall  = accept || (state == BUSY);
    done   = (state == DONE) && !flush;
    Result = done ? result_val : result_q;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      acc      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      f_q      <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      if (accept) begin
        f_q <= Funct3;
        cnt <= '0;
        a_q <= mag_a;
        b_q <= mag_b;
        // Divide-by-zero and signed overflow preload their final answers.
        if (div_zero) begin
          acc   <= {SrcA, {XLEN{1'b1}}};
          neg_q <= 1'b0;
        end else if (div_ovf) begin
          acc   <= {{XLEN{1'b0}}, SrcA};
          neg_q <= 1'b0;
        end else begin
          acc   <= '0;
          neg_q <= (Funct3[2] && Funct3[1]) ? sign_a : (sign_a ^ sign_b);
        end
      end else if (state == BUSY && !flush) begin
        cnt <= cnt + 1'b1;
        if (f_q[2]) begin
          acc <= div_acc_next;
          a_q <= a_q << 1;
        end else begin
          acc <= mul_acc_next;
          b_q <= b_q >> 1;
        end
      end
      if (done) result_q <= result_val;
    end
  end

endmodule
